// File: rtl/ir_pkg.sv
// Decision codes shared by the IR period detector, this command filter and the motor/LED stage,
// plus the 100 MHz period windows the detector classifies against.
package ir_pkg;

    localparam logic [2:0] CODE_NONE = 3'd0;
    localparam logic [2:0] CODE_R_B  = 3'd1;
    localparam logic [2:0] CODE_R_G  = 3'd2;
    localparam logic [2:0] CODE_B_G  = 3'd3;
    localparam logic [2:0] CODE_STOP = 3'd4;

    // Detector period windows in 100 MHz cycles (nominal period +/- 5 %).
    localparam int unsigned CLK_HZ         = 100_000_000;
    localparam int unsigned R_B_PERIOD_MIN = 95_000;     // 1 kHz
    localparam int unsigned R_B_PERIOD_MAX = 105_000;
    localparam int unsigned R_G_PERIOD_MIN = 190_000;    // 500 Hz
    localparam int unsigned R_G_PERIOD_MAX = 210_000;
    localparam int unsigned B_G_PERIOD_MIN = 316_667;    // 300 Hz
    localparam int unsigned B_G_PERIOD_MAX = 350_000;
    localparam int unsigned STOP_PERIOD_MIN = 475_000;   // 200 Hz, slowest code
    localparam int unsigned STOP_PERIOD_MAX = 525_000;

    typedef enum logic {
        ST_LOST,
        ST_TRACK
    } filt_state_e;

    // Codes 5..7 carry no meaning downstream and collapse to NONE.
    function automatic logic [2:0] sanitize_code(input logic [2:0] code);
        return (code > CODE_STOP) ? CODE_NONE : code;
    endfunction

endpackage

// File: rtl/ir_silence_timer.sv
// Saturating silence counter: cleared by each decision strobe, flags the cycle in which
// the count would reach timeout_cycles without a strobe.
module ir_silence_timer #(
    parameter int TIMEOUT_CYCLES = 2_000_000,
    parameter int TO_W           = 21
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic expire
);

    localparam logic [TO_W-1:0] SIL_MAX  = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] SIL_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] sil_reg;
    logic [TO_W-1:0] sil_next;

    always_comb begin
        sil_next = sil_reg;
        if (clear) begin
            sil_next = '0;
        end else if (sil_reg < SIL_MAX) begin
            sil_next = sil_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sil_reg <= '0;
        end else begin
            sil_reg <= sil_next;
        end
    end

    // The count lands on timeout_cycles at the coming edge; a strobe in this cycle cancels it.
    assign expire = !clear && (sil_reg == SIL_LAST);

endmodule

// File: rtl/ir_command_filter.sv
// Debounces detector decisions into a committed drive command and forces NONE when the
// IR signal has gone silent for too long.
module ir_command_filter
    import ir_pkg::*;
#(
    parameter int CONFIRM_N      = 4,
    parameter int STOP_CONFIRM_N = 2,
    parameter int TIMEOUT_CYCLES = 2_000_000,
    parameter int CNT_W          = 4,
    parameter int TO_W           = 21
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             done_i,
    input  logic [2:0]       decision_i,
    output logic [2:0]       cmd_o,
    output logic             cmd_valid_o,
    output logic [CNT_W-1:0] match_cnt_o,
    output logic             signal_lost_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THR_RUN  = CNT_W'(CONFIRM_N);
    localparam logic [CNT_W-1:0] THR_STOP = CNT_W'(STOP_CONFIRM_N);

    filt_state_e      state_reg, state_next;
    logic [2:0]       cand_reg, cand_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       cmd_reg, cmd_next;
    logic             valid_reg, valid_next;

    logic             expire;
    logic [2:0]       dec;
    logic [CNT_W-1:0] run_len;
    logic [CNT_W-1:0] thr;

    ir_silence_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_silence (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (done_i),
        .expire (expire)
    );

    assign dec = sanitize_code(decision_i);
    assign thr = (dec == CODE_STOP) ? THR_STOP : THR_RUN;

    // A zero count means no run is open, so even a decision equal to cand starts fresh.
    always_comb begin
        run_len = 1;
        if (dec == cand_reg && cnt_reg != '0) begin
            run_len = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        cand_next  = cand_reg;
        cnt_next   = cnt_reg;
        cmd_next   = cmd_reg;
        valid_next = 1'b0;
        if (done_i) begin
            state_next = ST_TRACK;
            cand_next  = dec;
            cnt_next   = run_len;
            if (run_len >= thr && dec != cmd_reg) begin
                cmd_next   = dec;
                valid_next = 1'b1;
            end
        end else if (state_reg == ST_TRACK && expire) begin
            state_next = ST_LOST;
            cand_next  = CODE_NONE;
            cnt_next   = '0;
            if (cmd_reg != CODE_NONE) begin
                cmd_next   = CODE_NONE;
                valid_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_LOST;
            cand_reg  <= CODE_NONE;
            cnt_reg   <= '0;
            cmd_reg   <= CODE_NONE;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cand_reg  <= cand_next;
            cnt_reg   <= cnt_next;
            cmd_reg   <= cmd_next;
            valid_reg <= valid_next;
        end
    end

    assign cmd_o         = cmd_reg;
    assign cmd_valid_o   = valid_reg;
    assign match_cnt_o   = cnt_reg;
    assign signal_lost_o = (state_reg == ST_LOST);

endmodule

// File: tb/tb_ir_command_filter.sv
// Bench for ir_command_filter: directed vector table, timeout corner sequences and a
// randomized run against a decision-history reference model.
module tb_ir_command_filter;
    import ir_pkg::*;

    localparam int CONFIRM_N      = 3;
    localparam int STOP_CONFIRM_N = 1;
    localparam int TIMEOUT_CYCLES = 100;
    localparam int CNT_W          = 4;
    localparam int TO_W           = 7;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             done_i = 1'b0;
    logic [2:0]       decision_i = 3'd0;
    logic [2:0]       cmd_o;
    logic             cmd_valid_o;
    logic [CNT_W-1:0] match_cnt_o;
    logic             signal_lost_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ir_command_filter #(
        .CONFIRM_N      (CONFIRM_N),
        .STOP_CONFIRM_N (STOP_CONFIRM_N),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W),
        .TO_W           (TO_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .done_i        (done_i),
        .decision_i    (decision_i),
        .cmd_o         (cmd_o),
        .cmd_valid_o   (cmd_valid_o),
        .match_cnt_o   (match_cnt_o),
        .signal_lost_o (signal_lost_o)
    );

    // Reference model: history of decisions since the last reset/timeout; the match count
    // is the length of the trailing run of identical entries.
    int m_hist[$];
    int m_cmd;
    int m_valid;
    int m_lost;
    int m_silent;

    function automatic int run_length();
        int r = 0;
        if (m_hist.size() == 0) return 0;
        for (int i = m_hist.size() - 1; i >= 0; i--) begin
            if (m_hist[i] == m_hist[m_hist.size() - 1]) r++;
            else break;
        end
        return (r > 15) ? 15 : r;
    endfunction

    task automatic model_update(input logic r, input logic d, input logic [2:0] c);
        int code;
        int run;
        m_valid = 0;
        if (!r) begin
            m_hist.delete();
            m_cmd = 0; m_lost = 1; m_silent = 0;
        end else if (d) begin
            code = (c > 4) ? 0 : int'(c);
            m_hist.push_back(code);
            if (m_hist.size() > 20) void'(m_hist.pop_front());
            run = run_length();
            if (run >= ((code == 4) ? STOP_CONFIRM_N : CONFIRM_N) && code != m_cmd) begin
                m_cmd = code;
                m_valid = 1;
            end
            m_lost = 0;
            m_silent = 0;
        end else begin
            if (m_silent < TIMEOUT_CYCLES) m_silent++;
            if (!m_lost && m_silent == TIMEOUT_CYCLES) begin
                m_lost = 1;
                m_hist.delete();
                if (m_cmd != 0) begin
                    m_cmd = 0;
                    m_valid = 1;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic d, input logic [2:0] c);
        rst_n = r; done_i = d; decision_i = c;
        @(posedge clk);
        model_update(r, d, c);
        #1;
        rst_n = 1'b1; done_i = 1'b0;
    endtask

    task automatic chk(input string name, input int ec, input int ev, input int en, input int el);
        checks++;
        if (int'(cmd_o) != ec || int'(cmd_valid_o) != ev || int'(match_cnt_o) != en ||
            int'(signal_lost_o) != el) begin
            failures++;
            $display("FAIL %s: got cmd=%0d valid=%0d cnt=%0d lost=%0d, want cmd=%0d valid=%0d cnt=%0d lost=%0d",
                     name, cmd_o, cmd_valid_o, match_cnt_o, signal_lost_o, ec, ev, en, el);
        end else begin
            $display("ok   %s: cmd=%0d valid=%0d cnt=%0d lost=%0d", name, cmd_o, cmd_valid_o,
                     match_cnt_o, signal_lost_o);
        end
    endtask

    task automatic chk_model(input string name);
        chk(name, m_cmd, m_valid, run_length(), m_lost);
    endtask

    task automatic idle(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 3'd0);
            chk_model(name);
        end
    endtask

    typedef struct {
        logic       rst;
        logic [2:0] code;
        int         gap;
        int         e_cmd;
        int         e_valid;
        int         e_cnt;
        int         e_lost;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // Directed table: each entry is a reset or a strobe, checked one cycle later, then gap idle cycles.
        vecs.push_back('{1'b0, CODE_NONE, 2, 0, 0, 0, 1});
        vecs.push_back('{1'b1, CODE_R_G, 9, 0, 0, 1, 0});
        vecs.push_back('{1'b1, CODE_R_G, 9, 0, 0, 2, 0});
        vecs.push_back('{1'b1, CODE_R_G, 3, 2, 1, 3, 0});
        vecs.push_back('{1'b0, CODE_NONE, 1, 0, 0, 0, 1});
        vecs.push_back('{1'b1, CODE_R_G, 2, 0, 0, 1, 0});
        vecs.push_back('{1'b1, CODE_R_G, 2, 0, 0, 2, 0});
        vecs.push_back('{1'b1, CODE_B_G, 2, 0, 0, 1, 0});
        vecs.push_back('{1'b1, CODE_R_G, 2, 0, 0, 1, 0});
        vecs.push_back('{1'b1, CODE_R_G, 2, 0, 0, 2, 0});
        vecs.push_back('{1'b1, CODE_R_G, 2, 2, 1, 3, 0});
        vecs.push_back('{1'b1, CODE_STOP, 2, 4, 1, 1, 0});
        vecs.push_back('{1'b1, CODE_STOP, 2, 4, 0, 2, 0});
        vecs.push_back('{1'b1, CODE_STOP, 2, 4, 0, 3, 0});
        vecs.push_back('{1'b1, 3'd6, 2, 4, 0, 1, 0});
        vecs.push_back('{1'b1, 3'd7, 2, 4, 0, 2, 0});
        vecs.push_back('{1'b1, CODE_NONE, 2, 0, 1, 3, 0});
        vecs.push_back('{1'b0, CODE_NONE, 1, 0, 0, 0, 1});
        vecs.push_back('{1'b1, CODE_R_B, 2, 0, 0, 1, 0});
        vecs.push_back('{1'b1, CODE_R_B, 2, 0, 0, 2, 0});
        vecs.push_back('{1'b1, CODE_R_B, 0, 1, 1, 3, 0});

        m_cmd = 0; m_valid = 0; m_lost = 1; m_silent = 0;
        step(1'b0, 1'b0, 3'd0);
        step(1'b0, 1'b0, 3'd0);

        foreach (vecs[k]) begin
            step(vecs[k].rst, vecs[k].rst, vecs[k].code);
            chk($sformatf("vec%0d", k), vecs[k].e_cmd, vecs[k].e_valid, vecs[k].e_cnt, vecs[k].e_lost);
            idle(vecs[k].gap, $sformatf("vec%0d_idle", k));
        end

        // cmd_o=R_B: 99 silent cycles keep it, the 100th forces NONE with one pulse.
        idle(99, "pre_timeout");
        step(1'b1, 1'b0, 3'd0);
        chk("timeout", 0, 1, 0, 1);
        step(1'b1, 1'b0, 3'd0);
        chk("timeout_after", 0, 0, 0, 1);

        // A strobe landing on the 100th silent cycle cancels the timeout.
        step(1'b1, 1'b1, CODE_R_B);
        chk("relock1", 0, 0, 1, 0);
        idle(99, "near_timeout");
        step(1'b1, 1'b1, CODE_R_B);
        chk("strobe_on_100th", 0, 0, 2, 0);
        step(1'b1, 1'b1, CODE_R_B);
        chk("count_continues", 1, 1, 3, 0);

        // Reset mid-confirmation discards the run.
        step(1'b0, 1'b0, 3'd0);
        step(1'b1, 1'b1, CODE_R_G);
        step(1'b1, 1'b1, CODE_R_G);
        chk("pre_reset_run", 0, 0, 2, 0);
        step(1'b0, 1'b1, CODE_R_G);
        chk("mid_reset", 0, 0, 0, 1);
        step(1'b1, 1'b1, CODE_R_G);
        chk("post_reset_strobe", 0, 0, 1, 0);

        // Randomized traffic, including long silences and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            int sel;
            sel = int'($urandom_range(0, 99));
            if (sel == 0) begin
                step(1'b0, 1'b0, 3'd0);
            end else if (sel < 3) begin
                idle(int'($urandom_range(90, 110)), "rand_silence");
                continue;
            end else if (sel < 45) begin
                step(1'b1, 1'b1, ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                                             : 3'($urandom_range(1, 2)));
            end else begin
                step(1'b1, 1'b0, 3'd0);
            end
            chk_model("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
